sdp_ring_delay: RTL and testbench
=================================

Name: sdp_ring_delay

Overview:
- Parametrised single-clock circular sample buffer built on simple-dual-port block RAM.
- Successor to the fixed 24x1024 two-clock SDP memory wrapper.
- Microphone samples are written sequentially; the beamformer reads any past sample by relative delay, for delay-and-sum steering.
- Adds internal write-pointer management, fill tracking, delay-to-address translation, validity flags and a read pipeline with a valid strobe.

Parameters:
- DATA_W, 24, sample width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W, derived, not overridable.

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  synchronous, active-high.
- clr  in  1  synchronous buffer clear; zeroes fill, wr_ptr untouched.
- wr_en  in  1  write wr_data at wr_ptr this cycle.
- wr_data  in  DATA_W  sample to store.
- rd_req  in  1  read request.
- rd_delay  in  ADDR_W  age of requested sample; 0 = newest written.
- rd_valid  out  1  read result strobe.
- rd_data  out  DATA_W  read sample; 0 when rd_hit=0.
- rd_hit  out  1  requested sample existed (rd_delay < fill at request).
- fill  out  ADDR_W+1  number of valid samples, 0..DEPTH.
- full  out  1  fill == DEPTH.
- wr_ptr  out  ADDR_W  next write address.

Behaviour:
- Reset: wr_ptr=0, fill=0, full=0, rd_valid=0, rd_hit=0, rd_data=0. All pipeline stages are cleared; in-flight reads are dropped. RAM contents are not cleared.
- Reset has priority over clr, wr_en and rd_req.
- Write: when wr_en=1, mem[wr_ptr] <= wr_data and wr_ptr <= wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0). fill increments and saturates at DEPTH. Once full, writes overwrite the oldest sample and are never refused.
- Read address: rd_addr = (wr_ptr - 1 - rd_delay) mod DEPTH, ADDR_W-bit wraparound arithmetic.
- Read snapshot: wr_ptr and fill are sampled as registered before any same-cycle write or clr. A same-cycle write is not visible to that read.
- Hit: hit = rd_req & (rd_delay < fill), using pre-update fill. The comparison is zero-extended to ADDR_W+1 bits.
- Collision: rd_delay = DEPTH-1 with fill = DEPTH addresses wr_ptr. If wr_en is also 1 in that cycle, the read returns the old (overwritten) data (read-first).
- Latency, macro absent: rd_valid, rd_hit and rd_data are registered and appear exactly 1 cycle after rd_req.
- Latency, macro present: see Optional Feature.
- Throughput: one read per cycle, back-to-back; results return in request order.
- Idle output: rd_valid=0 when no result is due. rd_data and rd_hit hold their last values; the bench checks them only when rd_valid=1.
- Miss: rd_valid=1, rd_hit=0, rd_data=0.
- clr:
  - fill <= 0 and full <= 0; wr_ptr and RAM are unchanged.
  - clr with wr_en in the same cycle gives fill=1 next cycle.
  - In-flight reads complete with their already-computed hit.
- full is a registered compare, updated in the same cycle as fill.

Optional Feature:
- Macro: SDP_RING_DELAY_OUT_REG_EN.
- Defined: an additional output register stage (pipelined read mode) is inserted on rd_data, rd_hit and rd_valid. Latency becomes 2 cycles; still one read per cycle. The extra stage resets to 0 under reset.
- Undefined: 1-cycle latency (bypass read mode). Port list is identical in both builds.

Test Plan (ADDR_W=4, DEPTH=16, DATA_W=24, macro undefined unless stated):
1. Reset, write 0x000001..0x000005 on consecutive cycles, then rd_delay=0 -> next cycle rd_valid=1, rd_hit=1, rd_data=0x000005; rd_delay=4 -> 0x000001; fill=5, wr_ptr=5.
2. After 5 writes, rd_delay=5 -> rd_valid=1, rd_hit=0, rd_data=0x000000.
3. Write 20 samples 0x100..0x113 -> fill=16, full=1, wr_ptr=4. rd_delay=15 -> 0x104. Wraparound is checked via the address computation crossing 0.
4. Full buffer, wr_ptr=4, wr_en with 0xABCDEF plus rd_req rd_delay=15 in the same cycle -> rd_data=0x104 (old). A following rd_delay=0 read -> 0xABCDEF.
5. clr with wr_en (data 0x55) in the same cycle -> fill=1, wr_ptr advances. rd_delay=0 -> hit, 0x55; rd_delay=1 -> miss.
6. SDP_RING_DELAY_OUT_REG_EN defined, 4 back-to-back reads -> 4 consecutive rd_valid pulses starting 2 cycles after the first rd_req, in order. Reset asserted mid-stream -> rd_valid=0 the next cycle and no stale results.

Source files
------------

// File: rtl/sdp_ring_delay_if.sv
// Sample-ring bus: write side, delay-read side and fill status.
// master = producer/beamformer side, slave = the ring buffer.
interface sdp_ring_delay_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
);
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_delay;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_hit;
  logic [ADDR_W:0]   fill;
  logic              full;
  logic [ADDR_W-1:0] wr_ptr;

  modport master (
    output clr, wr_en, wr_data,
    output rd_req, rd_delay,
    input  rd_valid, rd_data, rd_hit,
    input  fill, full, wr_ptr
  );

  modport slave (
    input  clr, wr_en, wr_data,
    input  rd_req, rd_delay,
    output rd_valid, rd_data, rd_hit,
    output fill, full, wr_ptr
  );
endinterface

// File: rtl/sdp_ring_delay.sv
// Circular sample buffer on SDP RAM, read by relative delay.
// SDP_RING_DELAY_OUT_REG_EN adds an output register (2-cycle reads).
module sdp_ring_delay #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input logic                clk,
  input logic                reset,
  sdp_ring_delay_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic valid;
    logic hit;
  } rd_st_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   fill_q;
  logic [ADDR_W:0]   fill_nxt;
  logic              full_q;

  logic [ADDR_W-1:0] rd_addr;
  logic              hit;
  rd_st_t            s1_q;
  logic [DATA_W-1:0] s1_data;

  // Read sees pre-write pointer and fill.
  assign rd_addr = ADDR_W'(wr_ptr_q - ADDR_W'(1)
                   - bus.rd_delay);
  assign hit = bus.rd_req
             & ({1'b0, bus.rd_delay} < fill_q);

  always_comb begin
    fill_nxt = fill_q;
    if (bus.clr)
      fill_nxt = {{ADDR_W{1'b0}}, bus.wr_en};
    else if (bus.wr_en && !full_q)
      fill_nxt = fill_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
    end else begin
      if (bus.wr_en)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      fill_q <= fill_nxt;
      full_q <= (fill_nxt == FULL_CNT);
    end
  end

  // No reset on the array so it maps to block RAM.
  // Both NBAs: a colliding read gets the old word.
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en)
      mem[wr_ptr_q] <= bus.wr_data;
    if (!reset && bus.rd_req)
      ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
    end else begin
      s1_q.valid <= bus.rd_req;
      if (bus.rd_req)
        s1_q.hit <= hit;
    end
  end

  assign s1_data = s1_q.hit ? ram_q : '0;

`ifdef SDP_RING_DELAY_OUT_REG_EN
  rd_st_t            s2_q;
  logic [DATA_W-1:0] s2_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_q    <= '0;
      s2_data <= '0;
    end else begin
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.hit <= s1_q.hit;
        s2_data  <= s1_data;
      end
    end
  end

  assign bus.rd_valid = s2_q.valid;
  assign bus.rd_hit   = s2_q.hit;
  assign bus.rd_data  = s2_data;
`else
  assign bus.rd_valid = s1_q.valid;
  assign bus.rd_hit   = s1_q.hit;
  assign bus.rd_data  = s1_data;
`endif

  assign bus.fill   = fill_q;
  assign bus.full   = full_q;
  assign bus.wr_ptr = wr_ptr_q;
endmodule

// File: tb/tb_sdp_ring_delay.sv
// Directed bench for sdp_ring_delay, DEPTH=16.
// Honours SDP_RING_DELAY_OUT_REG_EN for read latency.
module tb_sdp_ring_delay;
`ifdef SDP_RING_DELAY_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sdp_ring_delay_if #(
    .DATA_W(24), .ADDR_W(4)
  ) bus ();

  sdp_ring_delay #(
    .DATA_W(24), .ADDR_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [3:0] dly,
                    input logic hit,
                    input logic [23:0] dat);
    bus.rd_req   = 1'b1;
    bus.rd_delay = dly;
    cyc();
    bus.rd_req = 1'b0;
    for (int k = 1; k < LAT; k++) cyc();
    chk({tag, "_v"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_h"}, 32'(bus.rd_hit), 32'(hit));
    chk({tag, "_d"}, 32'(bus.rd_data), 32'(dat));
  endtask

  task automatic wr(input logic [23:0] dat);
    bus.wr_en   = 1'b1;
    bus.wr_data = dat;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    logic [23:0] exp4 [4];
    bus.clr      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_delay = '0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_fill", 32'(bus.fill), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("rst_v", 32'(bus.rd_valid), 32'd0);
    chk("rst_h", 32'(bus.rd_hit), 32'd0);
    chk("rst_d", 32'(bus.rd_data), 32'd0);

    for (int i = 1; i <= 5; i++) wr(24'(i));
    chk("t1_fill", 32'(bus.fill), 32'd5);
    chk("t1_ptr", 32'(bus.wr_ptr), 32'd5);
    rd("t1_d0", 4'd0, 1'b1, 24'h000005);
    rd("t1_d4", 4'd4, 1'b1, 24'h000001);
    cyc();
    chk("idle_v", 32'(bus.rd_valid), 32'd0);
    rd("t2_miss", 4'd5, 1'b0, 24'h000000);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) wr(24'h100 + 24'(i));
    chk("t3_fill", 32'(bus.fill), 32'd16);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ptr", 32'(bus.wr_ptr), 32'd4);
    rd("t3_d15", 4'd15, 1'b1, 24'h000104);
    rd("t3_d0", 4'd0, 1'b1, 24'h000113);
    rd("t3_d3", 4'd3, 1'b1, 24'h000110);

    bus.wr_en    = 1'b1;
    bus.wr_data  = 24'hABCDEF;
    bus.rd_req   = 1'b1;
    bus.rd_delay = 4'd15;
    cyc();
    bus.wr_en  = 1'b0;
    bus.rd_req = 1'b0;
    for (int k = 1; k < LAT; k++) cyc();
    chk("t4_v", 32'(bus.rd_valid), 32'd1);
    chk("t4_old", 32'(bus.rd_data), 32'h104);
    chk("t4_fill", 32'(bus.fill), 32'd16);
    rd("t4_new", 4'd0, 1'b1, 24'hABCDEF);

    bus.clr = 1'b1;
    wr(24'h55);
    bus.clr = 1'b0;
    chk("t5_fill", 32'(bus.fill), 32'd1);
    chk("t5_full", 32'(bus.full), 32'd0);
    chk("t5_ptr", 32'(bus.wr_ptr), 32'd6);
    rd("t5_d0", 4'd0, 1'b1, 24'h000055);
    rd("t5_d1", 4'd1, 1'b0, 24'h000000);

    wr(24'h56);
    wr(24'h57);
    wr(24'h58);
    exp4[0] = 24'h58;
    exp4[1] = 24'h57;
    exp4[2] = 24'h56;
    exp4[3] = 24'h55;
    for (int i = 0; i < 4 + LAT; i++) begin
      bus.rd_req   = (i < 4);
      bus.rd_delay = 4'(i);
      cyc();
      if (i >= LAT - 1 && i - LAT + 1 < 4) begin
        chk("b2b_v", 32'(bus.rd_valid), 32'd1);
        chk("b2b_d", 32'(bus.rd_data),
            32'(exp4[i - LAT + 1]));
      end else begin
        chk("b2b_idle", 32'(bus.rd_valid), 32'd0);
      end
    end
    bus.rd_req = 1'b0;

    bus.rd_req   = 1'b1;
    bus.rd_delay = 4'd0;
    cyc();
    reset = 1'b1;
    cyc();
    reset      = 1'b0;
    bus.rd_req = 1'b0;
    chk("mrst_v0", 32'(bus.rd_valid), 32'd0);
    chk("mrst_d0", 32'(bus.rd_data), 32'd0);
    cyc();
    chk("mrst_v1", 32'(bus.rd_valid), 32'd0);
    cyc();
    chk("mrst_v2", 32'(bus.rd_valid), 32'd0);
    chk("mrst_fill", 32'(bus.fill), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
